// File: rtl/uart_rx_fsm.sv
// UART receiver: start, DATA_BITS data (LSB first), even parity, one stop.
// Samples a 2-flop synchronized line on rising edges of an oversampling tick.
module uart_rx_fsm #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_error,
    output logic                 stop_error
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_e;

    state_e state_q, state_d;

    logic                 rx_s1_q, rx_s2_q;
    logic                 tick_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 pe_q, pe_d;
    logic                 se_q, se_d;

    logic tick_ev;
    logic rx_s;

    assign tick_ev = tick & ~tick_q;
    assign rx_s    = rx_s2_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            tick_q  <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            tick_q  <= tick;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pe_q    <= pe_d;
            se_q    <= se_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        pe_d    = pe_q;
        se_d    = se_q;

        unique case (state_q)
            IDLE: begin
                if (tick_ev && !rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (tick_ev) begin
                    if (cnt_q == HALF) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        // High at mid start bit is a glitch, not a frame
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick_ev) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (idx_q == LAST_BIT) begin
                            state_d = PARITY;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick_ev) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        perr_d  = rx_s ^ (^shift_q);
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick_ev) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        data_d  = shift_q;
                        pe_d    = perr_q;
                        se_d    = !rx_s;
                        valid_d = 1'b1;
                        state_d = rx_s ? IDLE : WAIT_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (tick_ev && rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign parity_error = pe_q;
    assign stop_error   = se_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: 16x oversample, tick pulse every 4 clk.
// Each bit is held 64 clk; strobes are captured on the falling clock edge.
module tb_uart_rx_fsm;

    localparam int BIT_CLK = 64;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_error;
    logic       stop_error;

    int tests;
    int fails;
    int vcnt;
    logic [7:0] cap_data;
    logic       cap_pe;
    logic       cap_se;

    uart_rx_fsm #(
        .OVERSAMPLE(16),
        .DATA_BITS (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .parity_error(parity_error),
        .stop_error  (stop_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            vcnt     <= vcnt + 1;
            cap_data <= rx_data;
            cap_pe   <= parity_error;
            cap_se   <= stop_error;
        end
    end

    task automatic hold_bit(input logic b, input int nbits);
        rx = b;
        repeat (nbits * BIT_CLK) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pflip,
                              input logic stp);
        hold_bit(1'b0, 1);
        for (int i = 0; i < 8; i++) hold_bit(d[i], 1);
        hold_bit((^d) ^ pflip, 1);
        hold_bit(stp, 1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rx  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid got %b want 0", rx_valid);
        end
        tests++;
        if (rx_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_data got %h want 00", rx_data);
        end
        tests++;
        if (parity_error !== 1'b0) begin
            fails++;
            $display("FAIL reset_pe got %b want 0", parity_error);
        end
        tests++;
        if (stop_error !== 1'b0) begin
            fails++;
            $display("FAIL reset_se got %b want 0", stop_error);
        end
        rst = 1'b1;
        hold_bit(1'b1, 2);
    endtask

    task automatic test_normal();
        int v0;
        v0 = vcnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        hold_bit(1'b1, 1);
        tests++;
        if (vcnt - v0 !== 1) begin
            fails++;
            $display("FAIL normal_cnt got %0d want 1", vcnt - v0);
        end
        tests++;
        if (cap_data !== 8'hA5) begin
            fails++;
            $display("FAIL normal_data got %h want a5", cap_data);
        end
        tests++;
        if (cap_pe !== 1'b0 || cap_se !== 1'b0) begin
            fails++;
            $display("FAIL normal_flags got pe=%b se=%b want 0 0",
                     cap_pe, cap_se);
        end
    endtask

    task automatic test_parity();
        int v0;
        v0 = vcnt;
        send_frame(8'h5A, 1'b1, 1'b1);
        hold_bit(1'b1, 1);
        tests++;
        if (vcnt - v0 !== 1) begin
            fails++;
            $display("FAIL parity_cnt got %0d want 1", vcnt - v0);
        end
        tests++;
        if (cap_data !== 8'h5A) begin
            fails++;
            $display("FAIL parity_data got %h want 5a", cap_data);
        end
        tests++;
        if (cap_pe !== 1'b1 || cap_se !== 1'b0) begin
            fails++;
            $display("FAIL parity_flags got pe=%b se=%b want 1 0",
                     cap_pe, cap_se);
        end
        tests++;
        if (parity_error !== 1'b1) begin
            fails++;
            $display("FAIL parity_hold got %b want 1", parity_error);
        end
    endtask

    task automatic test_stop_error();
        int v0;
        v0 = vcnt;
        send_frame(8'h99, 1'b0, 1'b0);
        hold_bit(1'b0, 2);
        hold_bit(1'b1, 3);
        tests++;
        if (vcnt - v0 !== 1) begin
            fails++;
            $display("FAIL stop_cnt got %0d want 1", vcnt - v0);
        end
        tests++;
        if (cap_data !== 8'h99) begin
            fails++;
            $display("FAIL stop_data got %h want 99", cap_data);
        end
        tests++;
        if (cap_pe !== 1'b0 || cap_se !== 1'b1) begin
            fails++;
            $display("FAIL stop_flags got pe=%b se=%b want 0 1",
                     cap_pe, cap_se);
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = vcnt;
        send_frame(8'h00, 1'b0, 1'b1);
        tests++;
        if (vcnt - v0 !== 1 || cap_data !== 8'h00) begin
            fails++;
            $display("FAIL b2b_first got cnt=%0d data=%h want 1 00",
                     vcnt - v0, cap_data);
        end
        tests++;
        if (cap_pe !== 1'b0 || cap_se !== 1'b0) begin
            fails++;
            $display("FAIL b2b_first_flags got pe=%b se=%b want 0 0",
                     cap_pe, cap_se);
        end
        send_frame(8'hFF, 1'b0, 1'b1);
        hold_bit(1'b1, 1);
        tests++;
        if (vcnt - v0 !== 2 || cap_data !== 8'hFF) begin
            fails++;
            $display("FAIL b2b_second got cnt=%0d data=%h want 2 ff",
                     vcnt - v0, cap_data);
        end
        tests++;
        if (cap_pe !== 1'b0 || cap_se !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second_flags got pe=%b se=%b want 0 0",
                     cap_pe, cap_se);
        end
    endtask

    task automatic test_glitch();
        int v0;
        v0 = vcnt;
        rx = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        hold_bit(1'b1, 2);
        tests++;
        if (vcnt - v0 !== 0) begin
            fails++;
            $display("FAIL glitch_cnt got %0d want 0", vcnt - v0);
        end
        send_frame(8'h3C, 1'b0, 1'b1);
        hold_bit(1'b1, 1);
        tests++;
        if (vcnt - v0 !== 1 || cap_data !== 8'h3C) begin
            fails++;
            $display("FAIL glitch_next got cnt=%0d data=%h want 1 3c",
                     vcnt - v0, cap_data);
        end
        tests++;
        if (cap_pe !== 1'b0 || cap_se !== 1'b0) begin
            fails++;
            $display("FAIL glitch_flags got pe=%b se=%b want 0 0",
                     cap_pe, cap_se);
        end
    endtask

    task automatic test_reset_mid();
        int v0;
        logic [7:0] d;
        d  = 8'hA5;
        v0 = vcnt;
        hold_bit(1'b0, 1);
        for (int i = 0; i < 4; i++) hold_bit(d[i], 1);
        rx = d[4];
        repeat (20) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst_out got data=%h v=%b want 00 0",
                     rx_data, rx_valid);
        end
        tests++;
        if (parity_error !== 1'b0 || stop_error !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst_flags got pe=%b se=%b want 0 0",
                     parity_error, stop_error);
        end
        rst = 1'b1;
        hold_bit(1'b1, 2);
        tests++;
        if (vcnt - v0 !== 0) begin
            fails++;
            $display("FAIL mid_rst_cnt got %0d want 0", vcnt - v0);
        end
        send_frame(8'h81, 1'b0, 1'b1);
        hold_bit(1'b1, 1);
        tests++;
        if (vcnt - v0 !== 1 || rx_data !== 8'h81) begin
            fails++;
            $display("FAIL mid_rst_next got cnt=%0d data=%h want 1 81",
                     vcnt - v0, rx_data);
        end
        tests++;
        if (parity_error !== 1'b0 || stop_error !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst_next_flags got pe=%b se=%b want 0 0",
                     parity_error, stop_error);
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        vcnt     = 0;
        cap_data = 8'h00;
        cap_pe   = 1'b0;
        cap_se   = 1'b0;
        rst      = 1'b0;
        rx       = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_normal();
        test_parity();
        test_stop_error();
        test_back_to_back();
        test_glitch();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
